// File: rtl/multi_timer_if.sv
// CPU register-bus and interrupt bundle for multi_timer.
// master = CPU side, slave = timer block.
interface multi_timer_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              enable;
  logic              we_n;
  logic [CH_W+1:0]   A;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] DO;
  logic              OE;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq_n;

  modport master (output enable, we_n, A, DI, input DO, OE, irq_vec, irq_n);
  modport slave  (input enable, we_n, A, DI, output DO, OE, irq_vec, irq_n);
endinterface

// File: rtl/multi_timer.sv
// NUM_CH-channel interval timer: per-channel prescaler, down-counter with one-shot or
// periodic reload, sticky flag; registered read port (1-cycle latency), wired-OR active-low IRQ.
module multi_timer #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic         clk,
  input logic         rst,
  multi_timer_if.slave bus
);
  logic [CH_W-1:0]   sel_ch;
  logic [1:0]        sel_reg;
  logic              wr;
  logic              rd;
  logic [NUM_CH-1:0] wr_count, wr_ctrl, wr_status, wr_reload, rd_status, tick;

  logic [DATA_W-1:0] count_q  [NUM_CH];
  logic [DATA_W-1:0] reload_q [NUM_CH];
  logic [9:0]        pre_q    [NUM_CH];
  logic [1:0]        psel_q   [NUM_CH];
  logic [NUM_CH-1:0] irq_en_q, periodic_q, run_q, flag_q, post_ovf_q;
  logic [DATA_W-1:0] do_q;
  logic [DATA_W-1:0] rd_data;
  logic              oe_q;

  // After a one-shot underflow the channel free-runs at /1 regardless of psel.
  function automatic logic [9:0] div_m1(input logic [1:0] psel, input logic post_ovf);
    logic [9:0] v;
    case (psel)
      2'd0:    v = 10'd0;
      2'd1:    v = 10'd7;
      2'd2:    v = 10'd63;
      default: v = 10'd1023;
    endcase
    if (post_ovf) v = 10'd0;
    return v;
  endfunction

  assign sel_ch  = bus.A[CH_W+1:2];
  assign sel_reg = bus.A[1:0];
  assign wr      = bus.enable & ~bus.we_n;
  assign rd      = bus.enable & bus.we_n;

  // Decoding only matches existing channels, so out-of-range accesses hit nothing.
  always_comb begin
    wr_count  = '0;
    wr_ctrl   = '0;
    wr_status = '0;
    wr_reload = '0;
    rd_status = '0;
    tick      = '0;
    rd_data   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tick[c] = run_q[c] && (pre_q[c] == div_m1(psel_q[c], post_ovf_q[c]));
      if (sel_ch == CH_W'(c)) begin
        wr_count[c]  = wr && (sel_reg == 2'd0);
        wr_ctrl[c]   = wr && (sel_reg == 2'd1);
        wr_status[c] = wr && (sel_reg == 2'd2);
        wr_reload[c] = wr && (sel_reg == 2'd3);
        rd_status[c] = rd && (sel_reg == 2'd2);
        case (sel_reg)
          2'd0: rd_data = count_q[c];
          2'd1: begin
            rd_data[7]   = run_q[c];
            rd_data[3:2] = psel_q[c];
            rd_data[1]   = periodic_q[c];
            rd_data[0]   = irq_en_q[c];
          end
          2'd2: begin
            rd_data[7] = flag_q[c];
            rd_data[6] = post_ovf_q[c];
          end
          default: rd_data = reload_q[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count_q[c]  <= '0;
        reload_q[c] <= '0;
        pre_q[c]    <= '0;
        psel_q[c]   <= '0;
      end
      irq_en_q   <= '0;
      periodic_q <= '0;
      run_q      <= '0;
      flag_q     <= '0;
      post_ovf_q <= '0;
      do_q       <= '0;
      oe_q       <= 1'b0;
    end else begin
      oe_q <= rd;
      if (rd) do_q <= rd_data;
      for (int c = 0; c < NUM_CH; c++) begin
        if (run_q[c]) pre_q[c] <= tick[c] ? 10'd0 : pre_q[c] + 10'd1;
        if (tick[c]) begin
          if (count_q[c] != '0)    count_q[c] <= count_q[c] - DATA_W'(1);
          else if (periodic_q[c])  count_q[c] <= reload_q[c];
          else begin
            count_q[c]    <= '1;
            post_ovf_q[c] <= 1'b1;
          end
        end
        // A flag being set outranks a same-edge status read or clear.
        if (tick[c] && (count_q[c] == '0))
          flag_q[c] <= 1'b1;
        else if (rd_status[c] || (wr_status[c] && bus.DI[7]))
          flag_q[c] <= 1'b0;
        if (wr_ctrl[c]) begin
          irq_en_q[c]   <= bus.DI[0];
          periodic_q[c] <= bus.DI[1];
          psel_q[c]     <= bus.DI[3:2];
          run_q[c]      <= bus.DI[7];
          post_ovf_q[c] <= 1'b0;
        end
        if (wr_reload[c]) reload_q[c] <= bus.DI;
        // Placed last so a COUNT write overrides a same-edge tick.
        if (wr_count[c]) begin
          count_q[c]    <= bus.DI;
          pre_q[c]      <= 10'd0;
          flag_q[c]     <= 1'b0;
          run_q[c]      <= 1'b1;
          post_ovf_q[c] <= 1'b0;
        end
      end
    end
  end

  assign bus.DO      = do_q;
  assign bus.OE      = oe_q;
  assign bus.irq_vec = flag_q & irq_en_q;
  assign bus.irq_n   = ~|(flag_q & irq_en_q);
endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer (3 channels, so channel 3 is out of range): directed scenarios with
// literal expectations, then random bus traffic, all compared every cycle against a reference model.
module tb_multi_timer;
  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_timer_if #(.NUM_CH(NCH), .DATA_W(8)) bus ();
  multi_timer #(.NUM_CH(NCH), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Reference state: one entry per channel, plain integers.
  int m_count[NCH], m_reload[NCH], m_pre[NCH], m_psel[NCH];
  bit m_en[NCH], m_per[NCH], m_run[NCH], m_flag[NCH], m_post[NCH];
  int m_do;
  bit m_oe;
  int divs[4] = '{1, 8, 64, 1024};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int reg_val(input int c, input int r);
    case (r)
      0: return m_count[c];
      1: return int'(m_run[c]) * 128 + m_psel[c] * 4 + int'(m_per[c]) * 2 + int'(m_en[c]);
      2: return int'(m_flag[c]) * 128 + int'(m_post[c]) * 64;
      default: return m_reload[c];
    endcase
  endfunction

  function automatic int exp_irq();
    int v;
    v = 0;
    for (int c = 0; c < NCH; c++) if (m_flag[c] && m_en[c]) v += (1 << c);
    return v;
  endfunction

  task automatic model_step();
    int ch, r, d, div;
    bit w, rd, hit, tk, unf;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_count[c] = 0; m_reload[c] = 0; m_pre[c] = 0; m_psel[c] = 0;
        m_en[c] = 0; m_per[c] = 0; m_run[c] = 0; m_flag[c] = 0; m_post[c] = 0;
      end
      m_do = 0;
      m_oe = 0;
      return;
    end
    ch = int'(bus.A[3:2]);
    r  = int'(bus.A[1:0]);
    d  = int'(bus.DI);
    w  = bus.enable && !bus.we_n;
    rd = bus.enable && bus.we_n;
    m_oe = rd;
    if (rd) m_do = (ch < NCH) ? reg_val(ch, r) : 0;
    for (int c = 0; c < NCH; c++) begin
      hit = (ch == c);
      div = m_post[c] ? 1 : divs[m_psel[c]];
      tk  = m_run[c] && (m_pre[c] == div - 1);
      unf = tk && (m_count[c] == 0);
      if (m_run[c]) m_pre[c] = tk ? 0 : (m_pre[c] + 1) % 1024;
      if (tk) m_count[c] = unf ? (m_per[c] ? m_reload[c] : 255) : m_count[c] - 1;
      if (unf && !m_per[c]) m_post[c] = 1;
      if (unf) m_flag[c] = 1;
      else if (hit && r == 2 && (rd || (w && (d & 128) != 0))) m_flag[c] = 0;
      if (hit && w && r == 1) begin
        m_en[c] = d[0]; m_per[c] = d[1]; m_psel[c] = (d >> 2) & 3; m_run[c] = d[7];
        m_post[c] = 0;
      end
      if (hit && w && r == 3) m_reload[c] = d;
      if (hit && w && r == 0) begin
        m_count[c] = d; m_pre[c] = 0; m_flag[c] = 0; m_run[c] = 1; m_post[c] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step();
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("DO", 32'(bus.DO), 32'(m_do));
      chk("OE", 32'(bus.OE), 32'(m_oe));
      chk("irq_vec", 32'(bus.irq_vec), 32'(exp_irq()));
      chk("irq_n", 32'(bus.irq_n), 32'(exp_irq() == 0));
    end
  end

  // Called at a negedge; the access happens on the next posedge, returns at the following negedge.
  task automatic bus_op(input bit write, input int ch, input int r, input int d);
    bus.enable = 1'b1;
    bus.we_n   = !write;
    bus.A      = 4'(ch * 4 + r);
    bus.DI     = 8'(d);
    @(negedge clk);
    bus.enable = 1'b0;
    bus.we_n   = 1'b1;
  endtask

  task automatic rd_chk(input string nm, input int ch, input int r, input int exp);
    bus_op(1'b0, ch, r, 0);
    chk(nm, 32'(bus.DO), 32'(exp));
    chk({nm, "_oe"}, 32'(bus.OE), 32'd1);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic directed();
    int t, t0, t1, s;
    // Interval at /1: COUNT=3 -> flag 4 edges later, then /1 free-run from all-ones.
    bus_op(1, 0, 1, 8'h01);
    bus_op(1, 0, 0, 3);
    t = cyc;
    wait_edge(t + 3); chk("t2_irq_n_early", 32'(bus.irq_n), 32'd1);
    wait_edge(t + 4); chk("t2_irq_n_set", 32'(bus.irq_n), 32'd0);
    chk("t2_irq_vec", 32'(bus.irq_vec), 32'h1);
    rd_chk("t2_count_ff", 0, 0, 8'hFF);
    rd_chk("t2_status_c0", 0, 2, 8'hC0);
    rd_chk("t2_status_40", 0, 2, 8'h40);
    chk("t2_irq_n_clr", 32'(bus.irq_n), 32'd1);
    bus_op(1, 0, 1, 8'h00);

    // Periodic /64, RELOAD=2: a flag every 192 cycles, cleared by STATUS write in between.
    bus_op(1, 1, 1, 8'h0B);
    bus_op(1, 1, 3, 2);
    bus_op(1, 1, 0, 2);
    t = cyc;
    for (int p = 1; p <= 5; p++) begin
      wait_edge(t + p * 192 - 1); chk("t3_before", 32'(bus.irq_vec[1]), 32'd0);
      wait_edge(t + p * 192);     chk("t3_at", 32'(bus.irq_vec[1]), 32'd1);
      bus_op(1, 1, 2, 8'h80);
      chk("t3_cleared", 32'(bus.irq_vec[1]), 32'd0);
    end

    // Status read on the flag-setting edge sees the old flag; the set survives.
    wait_edge(t + 6 * 192 - 1);
    bus_op(0, 1, 2, 0);
    chk("t4_do_old_flag", 32'(bus.DO), 32'h00);
    chk("t4_flag_kept", 32'(bus.irq_vec[1]), 32'd1);
    chk("t4_irq_n", 32'(bus.irq_n), 32'd0);
    // COUNT write on a tick edge.
    wait_edge(t + 7 * 192 - 129);
    bus_op(1, 1, 0, 8'h55);
    rd_chk("t4_count_wins", 1, 0, 8'h55);
    chk("t4_flag_wiped", 32'(bus.irq_vec[1]), 32'd0);

    // Independent channels: ch1 /8 N=1, ch0 /1 N=10.
    bus_op(1, 0, 1, 8'h01);
    bus_op(1, 1, 1, 8'h05);
    bus_op(1, 1, 0, 1);
    t1 = cyc;
    bus_op(1, 0, 0, 10);
    t0 = cyc;
    wait_edge(t0 + 10); chk("t5_none", 32'(bus.irq_vec), 32'h0);
    wait_edge(t0 + 11); chk("t5_ch0", 32'(bus.irq_vec), 32'h1);
    wait_edge(t1 + 15); chk("t5_ch0_only", 32'(bus.irq_vec), 32'h1);
    wait_edge(t1 + 16); chk("t5_both", 32'(bus.irq_vec), 32'h3);
    bus_op(1, 0, 2, 8'h80);
    chk("t5_ch1_left", 32'(bus.irq_vec), 32'h2);
    chk("t5_irq_n", 32'(bus.irq_n), 32'd0);

    // Out-of-range channel: writes ignored, reads give 0 with OE.
    bus_op(1, 3, 3, 8'hAA);
    rd_chk("oor_read", 3, 3, 0);

    // run=0 freezes count and prescaler; resume keeps the remaining interval (48 total at /8, N=5).
    bus_op(1, 2, 1, 8'h05);
    bus_op(1, 2, 0, 5);
    t = cyc;
    wait_edge(t + 9);
    bus_op(1, 2, 1, 8'h05);
    rd_chk("t6_frozen_a", 2, 0, 4);
    wait_edge(t + 60);
    rd_chk("t6_frozen_b", 2, 0, 4);
    bus_op(1, 2, 1, 8'h85);
    s = cyc;
    wait_edge(s + 37); chk("t6_not_yet", 32'(bus.irq_vec[2]), 32'd0);
    wait_edge(s + 38); chk("t6_flag", 32'(bus.irq_vec[2]), 32'd1);

    // Reset for two cycles while channels are counting.
    bus_op(1, 1, 1, 8'h85);
    wait_edge(cyc + 5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_do", 32'(bus.DO), 32'h0);
    chk("rst_oe", 32'(bus.OE), 32'd0);
    chk("rst_irq_n", 32'(bus.irq_n), 32'd1);
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 4; r++)
        rd_chk("rst_reg", c, r, 0);
  endtask

  task automatic random_phase();
    int k, ch, r, d, ps;
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 99);
      rst = ($urandom_range(0, 999) == 0);
      bus.enable = 1'b0;
      bus.we_n   = 1'b1;
      if (k < 35) begin
        ch = $urandom_range(0, 3);
        r  = $urandom_range(0, 3);
        d  = $urandom_range(0, 255);
        if (r == 1) begin
          ps = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
          d  = (d & 'hF3) | (ps << 2);
        end
        bus.enable = 1'b1;
        bus.we_n   = 1'($urandom_range(0, 1));
        bus.A      = 4'(ch * 4 + r);
        bus.DI     = 8'(d);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    bus.enable = 1'b0;
    bus.we_n   = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.we_n   = 1'b1;
    bus.A      = '0;
    bus.DI     = '0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("init_oe", 32'(bus.OE), 32'd0);
    chk("init_irq_n", 32'(bus.irq_n), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    directed();
    random_phase();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
